// File: rtl/uart_ctrl_sequencer.sv
// UART control sequencer: CPU-driven TX start/done FSM, RX write-back and CPU/RX data-register arbitration.
// Optional macro UART_RX_OVERRUN_EN adds the sticky rx_ovr_o overrun flag.
module uart_ctrl_sequencer #(
    parameter int unsigned TX_TIMEOUT_CYC = 200_000,
    parameter int unsigned RX_W           = 8
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            ctrl_we_i,
    input  logic [1:0]      ctrl_wdata_i,
    input  logic            usr_we_i,
    input  logic [31:0]     usr_data_i,
    input  logic            rx_valid_i,
    input  logic [RX_W-1:0] rx_data_i,
    input  logic            tx_done_i,
    output logic            tx_start_o,
    output logic            hold_ctrl_o,
    output logic            wr1_o,
    output logic [31:0]     in1_o,
    output logic            wr2_o,
    output logic [31:0]     in2_o,
    output logic            send_o,
    output logic            new_rx_o,
`ifdef UART_RX_OVERRUN_EN
    output logic            tx_err_o,
    output logic            rx_ovr_o
`else
    output logic            tx_err_o
`endif
);

    localparam int unsigned CNT_W = $clog2(TX_TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TX_TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_DONE
    } tx_state_e;

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_set;

    logic             pend_valid_q, pend_valid_d;
    logic [31:0]      pend_data_q, pend_data_d;
    logic             rx_clr;

    // TX sequencing
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            tx_err_o <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (err_set) begin
                tx_err_o <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tx_start_o = 1'b0;
        err_set    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (ctrl_we_i && ctrl_wdata_i[0]) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                tx_start_o = 1'b1;
                cnt_d      = '0;
                state_d    = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                cnt_d = cnt_q + 1'b1;
                if (tx_done_i) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    err_set = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign send_o = (state_q != ST_IDLE);

    // Data-register arbitration: RX always owns the cycle; a displaced CPU word is replayed next cycle.
    always_comb begin
        hold_ctrl_o           = rx_valid_i;
        wr2_o                 = rx_valid_i;
        in2_o                 = '0;
        if (rx_valid_i) begin
            in2_o[RX_W-1:0] = rx_data_i;
        end
        wr1_o        = 1'b0;
        in1_o        = usr_data_i;
        pend_valid_d = pend_valid_q;
        pend_data_d  = pend_data_q;
        if (rx_valid_i) begin
            if (usr_we_i) begin
                pend_valid_d = 1'b1;
                pend_data_d  = usr_data_i;
            end
        end else if (pend_valid_q) begin
            wr1_o = 1'b1;
            in1_o = pend_data_q;
            if (usr_we_i) begin
                pend_data_d = usr_data_i;
            end else begin
                pend_valid_d = 1'b0;
            end
        end else begin
            wr1_o = usr_we_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_valid_q <= 1'b0;
            pend_data_q  <= '0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_data_q  <= pend_data_d;
        end
    end

    // RX status; a new byte takes priority over a simultaneous CPU clear
    assign rx_clr = ctrl_we_i && !ctrl_wdata_i[1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            new_rx_o <= 1'b0;
        end else if (rx_valid_i) begin
            new_rx_o <= 1'b1;
        end else if (rx_clr) begin
            new_rx_o <= 1'b0;
        end
    end

`ifdef UART_RX_OVERRUN_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_ovr_o <= 1'b0;
        end else if (rx_valid_i && new_rx_o) begin
            rx_ovr_o <= 1'b1;
        end else if (rx_clr) begin
            rx_ovr_o <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_uart_ctrl_sequencer.sv
// Directed self-checking bench for uart_ctrl_sequencer; a second instance with a short timeout covers TX abort.
module tb_uart_ctrl_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        ctrl_we, ctrl_we2;
    logic [1:0]  ctrl_wdata;
    logic        usr_we;
    logic [31:0] usr_data;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        tx_done;

    logic        tx_start, hold_ctrl, wr1, wr2, send, new_rx, tx_err;
    logic [31:0] in1, in2;
    logic        t_tx_start, t_hold_ctrl, t_wr1, t_wr2, t_send, t_new_rx, t_tx_err;
    logic [31:0] t_in1, t_in2;
`ifdef UART_RX_OVERRUN_EN
    logic        rx_ovr, t_rx_ovr;
`endif

    int checks = 0;
    int fails  = 0;

    always #5 clk_i = ~clk_i;

    uart_ctrl_sequencer #(.TX_TIMEOUT_CYC(100), .RX_W(8)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .ctrl_we_i(ctrl_we), .ctrl_wdata_i(ctrl_wdata),
        .usr_we_i(usr_we), .usr_data_i(usr_data), .rx_valid_i(rx_valid), .rx_data_i(rx_data),
        .tx_done_i(tx_done), .tx_start_o(tx_start), .hold_ctrl_o(hold_ctrl), .wr1_o(wr1),
        .in1_o(in1), .wr2_o(wr2), .in2_o(in2), .send_o(send), .new_rx_o(new_rx),
`ifdef UART_RX_OVERRUN_EN
        .tx_err_o(tx_err), .rx_ovr_o(rx_ovr)
`else
        .tx_err_o(tx_err)
`endif
    );

    uart_ctrl_sequencer #(.TX_TIMEOUT_CYC(16), .RX_W(8)) dut_to (
        .clk_i(clk_i), .rst_ni(rst_ni), .ctrl_we_i(ctrl_we2), .ctrl_wdata_i(ctrl_wdata),
        .usr_we_i(1'b0), .usr_data_i(32'h0), .rx_valid_i(1'b0), .rx_data_i(8'h00),
        .tx_done_i(1'b0), .tx_start_o(t_tx_start), .hold_ctrl_o(t_hold_ctrl), .wr1_o(t_wr1),
        .in1_o(t_in1), .wr2_o(t_wr2), .in2_o(t_in2), .send_o(t_send), .new_rx_o(t_new_rx),
`ifdef UART_RX_OVERRUN_EN
        .tx_err_o(t_tx_err), .rx_ovr_o(t_rx_ovr)
`else
        .tx_err_o(t_tx_err)
`endif
    );

    task automatic test_reset();
        rst_ni = 1'b0; ctrl_we = 1'b0; ctrl_we2 = 1'b0; ctrl_wdata = 2'b00;
        usr_we = 1'b0; usr_data = '0; rx_valid = 1'b0; rx_data = '0; tx_done = 1'b0;
        #2;
        checks++; if ({tx_start, hold_ctrl, wr1, wr2, send, new_rx, tx_err} !== 7'b0) begin
            fails++; $display("FAIL reset_outputs: got %b expected 0000000", {tx_start, hold_ctrl, wr1, wr2, send, new_rx, tx_err}); end
        checks++; if (in1 !== 32'h0 || in2 !== 32'h0) begin
            fails++; $display("FAIL reset_data: got in1=%h in2=%h expected 0", in1, in2); end
        checks++; if ({t_send, t_tx_err, t_tx_start} !== 3'b0) begin
            fails++; $display("FAIL reset_to_inst: got %b expected 000", {t_send, t_tx_err, t_tx_start}); end
`ifdef UART_RX_OVERRUN_EN
        checks++; if (rx_ovr !== 1'b0) begin fails++; $display("FAIL reset_ovr: got %b expected 0", rx_ovr); end
`endif
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_tx();
        int starts;
        int lows;
        ctrl_we = 1'b1; ctrl_wdata = 2'b01;
        @(negedge clk_i);
        ctrl_we = 1'b0; ctrl_wdata = 2'b00; #1;
        checks++; if (tx_start !== 1'b1) begin fails++; $display("FAIL tx_start_pulse: got %b expected 1", tx_start); end
        checks++; if (send !== 1'b1) begin fails++; $display("FAIL tx_send_set: got %b expected 1", send); end
        @(negedge clk_i); #1;
        checks++; if (tx_start !== 1'b0) begin fails++; $display("FAIL tx_start_width: got %b expected 0", tx_start); end
        // request while busy, plus a write of 0 to bit 0: both must be ignored
        ctrl_we = 1'b1; ctrl_wdata = 2'b11;
        starts = 0; lows = 0;
        for (int i = 0; i < 47; i++) begin
            @(negedge clk_i);
            ctrl_we = 1'b0; ctrl_wdata = 2'b10;
            if (i == 1) ctrl_we = 1'b1;
            if (i == 2) ctrl_we = 1'b0;
            #1;
            if (tx_start === 1'b1) starts++;
            if (send !== 1'b1) lows++;
        end
        ctrl_wdata = 2'b00;
        checks++; if (starts !== 0) begin fails++; $display("FAIL tx_no_restart: got %0d expected 0", starts); end
        checks++; if (lows !== 0) begin fails++; $display("FAIL tx_send_held: got %0d low cycles expected 0", lows); end
        @(negedge clk_i);
        tx_done = 1'b1; #1;
        checks++; if (send !== 1'b1) begin fails++; $display("FAIL tx_send_at_done: got %b expected 1", send); end
        @(negedge clk_i);
        tx_done = 1'b0; #1;
        checks++; if (send !== 1'b0) begin fails++; $display("FAIL tx_send_clear: got %b expected 0", send); end
        checks++; if (tx_err !== 1'b0) begin fails++; $display("FAIL tx_no_err: got %b expected 0", tx_err); end
        @(negedge clk_i); #1;
        checks++; if (tx_start !== 1'b0 || send !== 1'b0) begin
            fails++; $display("FAIL tx_idle_after: got start=%b send=%b expected 0 0", tx_start, send); end
    endtask

    task automatic test_timeout();
        int lows;
        checks++; if (t_tx_err !== 1'b0) begin fails++; $display("FAIL to_err_before: got %b expected 0", t_tx_err); end
        ctrl_we2 = 1'b1; ctrl_wdata = 2'b01;
        @(negedge clk_i);
        ctrl_we2 = 1'b0; ctrl_wdata = 2'b00; #1;
        checks++; if (t_tx_start !== 1'b1) begin fails++; $display("FAIL to_start: got %b expected 1", t_tx_start); end
        lows = 0;
        for (int i = 2; i <= 17; i++) begin
            @(negedge clk_i); #1;
            if (t_send !== 1'b1) lows++;
        end
        checks++; if (lows !== 0) begin fails++; $display("FAIL to_send_held: got %0d low cycles expected 0", lows); end
        checks++; if (t_tx_err !== 1'b0) begin fails++; $display("FAIL to_err_early: got %b expected 0", t_tx_err); end
        @(negedge clk_i); #1;
        checks++; if (t_send !== 1'b0) begin fails++; $display("FAIL to_send_fall: got %b expected 0", t_send); end
        checks++; if (t_tx_err !== 1'b1) begin fails++; $display("FAIL to_err_set: got %b expected 1", t_tx_err); end
        repeat (5) @(negedge clk_i);
        #1;
        checks++; if (t_tx_err !== 1'b1 || t_tx_start !== 1'b0) begin
            fails++; $display("FAIL to_err_sticky: got err=%b start=%b expected 1 0", t_tx_err, t_tx_start); end
    endtask

    task automatic test_rx();
        @(negedge clk_i);
        rx_valid = 1'b1; rx_data = 8'hA5; #1;
        checks++; if (wr2 !== 1'b1 || hold_ctrl !== 1'b1) begin
            fails++; $display("FAIL rx_same_cycle: got wr2=%b hold=%b expected 1 1", wr2, hold_ctrl); end
        checks++; if (in2 !== 32'h0000_00A5) begin fails++; $display("FAIL rx_in2: got %h expected 000000a5", in2); end
        checks++; if (new_rx !== 1'b0) begin fails++; $display("FAIL rx_new_latency: got %b expected 0", new_rx); end
        @(negedge clk_i);
        rx_valid = 1'b0; rx_data = 8'h00; #1;
        checks++; if (new_rx !== 1'b1 || wr2 !== 1'b0) begin
            fails++; $display("FAIL rx_new_set: got new_rx=%b wr2=%b expected 1 0", new_rx, wr2); end
        ctrl_we = 1'b1; ctrl_wdata = 2'b10;
        @(negedge clk_i);
        ctrl_we = 1'b0; ctrl_wdata = 2'b00; #1;
        checks++; if (new_rx !== 1'b1 || send !== 1'b0) begin
            fails++; $display("FAIL rx_keep_on_bit1: got new_rx=%b send=%b expected 1 0", new_rx, send); end
        ctrl_we = 1'b1;
        @(negedge clk_i);
        ctrl_we = 1'b0; #1;
        checks++; if (new_rx !== 1'b0) begin fails++; $display("FAIL rx_clear: got %b expected 0", new_rx); end
        ctrl_we = 1'b1; rx_valid = 1'b1; rx_data = 8'h5A;
        @(negedge clk_i);
        ctrl_we = 1'b0; rx_valid = 1'b0; #1;
        checks++; if (new_rx !== 1'b1) begin fails++; $display("FAIL rx_set_wins: got %b expected 1", new_rx); end
        ctrl_we = 1'b1;
        @(negedge clk_i);
        ctrl_we = 1'b0; #1;
        checks++; if (new_rx !== 1'b0) begin fails++; $display("FAIL rx_clear2: got %b expected 0", new_rx); end
    endtask

    task automatic test_collision();
        @(negedge clk_i);
        usr_we = 1'b1; usr_data = 32'h1234_5678; #1;
        checks++; if (wr1 !== 1'b1 || in1 !== 32'h1234_5678 || hold_ctrl !== 1'b0) begin
            fails++; $display("FAIL col_passthru: got wr1=%b in1=%h hold=%b expected 1 12345678 0", wr1, in1, hold_ctrl); end
        @(negedge clk_i);
        usr_data = 32'hDEAD_BEEF; rx_valid = 1'b1; rx_data = 8'h3C; #1;
        checks++; if (wr1 !== 1'b0 || hold_ctrl !== 1'b1 || wr2 !== 1'b1 || in2 !== 32'h3C) begin
            fails++; $display("FAIL col_rx_wins: got wr1=%b hold=%b wr2=%b in2=%h expected 0 1 1 3c", wr1, hold_ctrl, wr2, in2); end
        @(negedge clk_i);
        usr_we = 1'b0; usr_data = '0; rx_valid = 1'b0; #1;
        checks++; if (wr1 !== 1'b1 || in1 !== 32'hDEAD_BEEF || hold_ctrl !== 1'b0) begin
            fails++; $display("FAIL col_replay: got wr1=%b in1=%h expected 1 deadbeef", wr1, in1); end
        @(negedge clk_i); #1;
        checks++; if (wr1 !== 1'b0) begin fails++; $display("FAIL col_drained: got %b expected 0", wr1); end
        ctrl_we = 1'b1;
        @(negedge clk_i);
        ctrl_we = 1'b0;
    endtask

    task automatic test_back_to_back();
        // replay collides with a new CPU write
        @(negedge clk_i);
        usr_we = 1'b1; usr_data = 32'h1111_0001; rx_valid = 1'b1; #1;
        checks++; if (wr1 !== 1'b0) begin fails++; $display("FAIL b2b_a: got %b expected 0", wr1); end
        @(negedge clk_i);
        usr_data = 32'h2222_0002; rx_valid = 1'b0; #1;
        checks++; if (wr1 !== 1'b1 || in1 !== 32'h1111_0001) begin
            fails++; $display("FAIL b2b_first: got wr1=%b in1=%h expected 1 11110001", wr1, in1); end
        @(negedge clk_i);
        usr_we = 1'b0; usr_data = '0; #1;
        checks++; if (wr1 !== 1'b1 || in1 !== 32'h2222_0002) begin
            fails++; $display("FAIL b2b_second: got wr1=%b in1=%h expected 1 22220002", wr1, in1); end
        @(negedge clk_i); #1;
        checks++; if (wr1 !== 1'b0) begin fails++; $display("FAIL b2b_drain1: got %b expected 0", wr1); end
        // replay collides with RX: buffer holds
        usr_we = 1'b1; usr_data = 32'h3333_0003; rx_valid = 1'b1;
        @(negedge clk_i);
        usr_data = 32'h4444_0004; rx_valid = 1'b0; #1;
        checks++; if (wr1 !== 1'b1 || in1 !== 32'h3333_0003) begin
            fails++; $display("FAIL b2b_w3: got wr1=%b in1=%h expected 1 33330003", wr1, in1); end
        @(negedge clk_i);
        usr_we = 1'b0; usr_data = '0; rx_valid = 1'b1; #1;
        checks++; if (wr1 !== 1'b0 || hold_ctrl !== 1'b1) begin
            fails++; $display("FAIL b2b_hold: got wr1=%b hold=%b expected 0 1", wr1, hold_ctrl); end
        @(negedge clk_i);
        rx_valid = 1'b0; #1;
        checks++; if (wr1 !== 1'b1 || in1 !== 32'h4444_0004) begin
            fails++; $display("FAIL b2b_w4: got wr1=%b in1=%h expected 1 44440004", wr1, in1); end
        // full buffer + RX + CPU write: newest word overwrites
        @(negedge clk_i);
        usr_we = 1'b1; usr_data = 32'h5555_0005; rx_valid = 1'b1;
        @(negedge clk_i);
        usr_data = 32'h6666_0006; rx_valid = 1'b0;
        @(negedge clk_i);
        usr_data = 32'h7777_0007; rx_valid = 1'b1;
        @(negedge clk_i);
        usr_we = 1'b0; usr_data = '0; rx_valid = 1'b0; #1;
        checks++; if (wr1 !== 1'b1 || in1 !== 32'h7777_0007) begin
            fails++; $display("FAIL b2b_overwrite: got wr1=%b in1=%h expected 1 77770007", wr1, in1); end
        @(negedge clk_i); #1;
        checks++; if (wr1 !== 1'b0) begin fails++; $display("FAIL b2b_drain2: got %b expected 0", wr1); end
        ctrl_we = 1'b1;
        @(negedge clk_i);
        ctrl_we = 1'b0;
    endtask

`ifdef UART_RX_OVERRUN_EN
    task automatic test_overrun();
        @(negedge clk_i);
        rx_valid = 1'b1; rx_data = 8'hA1;
        @(negedge clk_i);
        rx_valid = 1'b0; #1;
        checks++; if (rx_ovr !== 1'b0 || new_rx !== 1'b1) begin
            fails++; $display("FAIL ovr_single: got ovr=%b new_rx=%b expected 0 1", rx_ovr, new_rx); end
        @(negedge clk_i);
        rx_valid = 1'b1; rx_data = 8'hB2; #1;
        checks++; if (wr2 !== 1'b1 || in2 !== 32'hB2) begin
            fails++; $display("FAIL ovr_written: got wr2=%b in2=%h expected 1 b2", wr2, in2); end
        @(negedge clk_i);
        rx_valid = 1'b0; #1;
        checks++; if (rx_ovr !== 1'b1 || new_rx !== 1'b1) begin
            fails++; $display("FAIL ovr_set: got ovr=%b new_rx=%b expected 1 1", rx_ovr, new_rx); end
        ctrl_we = 1'b1; ctrl_wdata = 2'b00;
        @(negedge clk_i);
        ctrl_we = 1'b0; #1;
        checks++; if (rx_ovr !== 1'b0 || new_rx !== 1'b0) begin
            fails++; $display("FAIL ovr_clear: got ovr=%b new_rx=%b expected 0 0", rx_ovr, new_rx); end
    endtask
`endif

    task automatic test_reset_mid_tx();
        int starts;
        @(negedge clk_i);
        ctrl_we = 1'b1; ctrl_wdata = 2'b01;
        @(negedge clk_i);
        ctrl_we = 1'b0; ctrl_wdata = 2'b00;
        repeat (3) @(negedge clk_i);
        #1;
        checks++; if (send !== 1'b1) begin fails++; $display("FAIL rst_busy: got %b expected 1", send); end
        #1 rst_ni = 1'b0;
        #1;
        checks++; if ({send, tx_start, tx_err, new_rx} !== 4'b0) begin
            fails++; $display("FAIL rst_async: got %b expected 0000", {send, tx_start, tx_err, new_rx}); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        starts = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i); #1;
            if (tx_start === 1'b1 || send === 1'b1) starts++;
        end
        checks++; if (starts !== 0) begin fails++; $display("FAIL rst_no_start: got %0d busy cycles expected 0", starts); end
        // reset with a pending CPU word discards it
        @(negedge clk_i);
        usr_we = 1'b1; usr_data = 32'hCAFE_0001; rx_valid = 1'b1;
        @(negedge clk_i);
        usr_we = 1'b0; usr_data = '0; rx_valid = 1'b0; #1;
        checks++; if (wr1 !== 1'b1 || in1 !== 32'hCAFE_0001) begin
            fails++; $display("FAIL rst_pend_pre: got wr1=%b in1=%h expected 1 cafe0001", wr1, in1); end
        #1 rst_ni = 1'b0;
        #1;
        checks++; if (wr1 !== 1'b0 || new_rx !== 1'b0) begin
            fails++; $display("FAIL rst_pend_drop: got wr1=%b new_rx=%b expected 0 0", wr1, new_rx); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i); #1;
        checks++; if (wr1 !== 1'b0) begin fails++; $display("FAIL rst_pend_after: got %b expected 0", wr1); end
    endtask

    initial begin
        test_reset();
        test_tx();
        test_timeout();
        test_rx();
        test_collision();
        test_back_to_back();
`ifdef UART_RX_OVERRUN_EN
        test_overrun();
`endif
        test_reset_mid_tx();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
